// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between a requester and seq_alu.
//   Request : in_valid, A, B, function_select_lines (requester -> ALU)
//             in_ready (ALU -> requester), accept when in_valid && in_ready
//   Response: result, mul_high, SREG {V,N,Z,C}, out_valid (one-cycle pulse)
// master = requester side, slave = ALU side.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       function_select_lines;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] mul_high;
   logic [3:0]       SREG;
   logic             out_valid;

   modport master (
      output in_valid, A, B, function_select_lines,
      input  in_ready, result, mul_high, SREG, out_valid
   );

   modport slave (
      input  in_valid, A, B, function_select_lines,
      output in_ready, result, mul_high, SREG, out_valid
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with an iterative shift-add multiplier.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seq_alu_if.slave
//           - single-cycle ops: outputs written on the accept edge, out_valid next cycle
//           - MUL (opcode 15): WIDTH shift-add steps, in_ready low while busy
//           - SREG = {V, N, Z, C}
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7;
   localparam logic [3:0] OP_ASR = 4'd8,  OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_CMP = 4'd11;
   localparam logic [3:0] OP_INC = 4'd12, OP_DEC = 4'd13, OP_PAS = 4'd14, OP_MUL = 4'd15;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   result_reg, mul_high_reg;
   logic [3:0]         sreg_reg;
   logic               out_valid_reg;
   logic [2*WIDTH-1:0] mcand_reg, acc_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [SHW:0]       cnt_reg;

   logic               accept;
   logic [3:0]         op;
   logic [SHW-1:0]     amt;
   logic [WIDTH-1:0]   op2;
   logic [WIDTH:0]     arith;
   logic [WIDTH:0]     sh;
   logic [2*WIDTH-1:0] rot;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   prod_hi;

   assign op     = bus.function_select_lines;
   assign amt    = bus.B[SHW-1:0];
   assign accept = bus.in_valid && bus.in_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept && op == OP_MUL) state_next = BUSY;
         BUSY: if (cnt_reg == CNT_LAST)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.in_ready = (state_reg == IDLE);
   end

   // ---------------- single-cycle datapath ----------------
   always_comb begin
      // INC/DEC reuse the adder/subtractor with a constant 1 as second operand
      op2     = (op == OP_INC || op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.B;
      arith   = '0;
      sh      = '0;
      rot     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD, OP_INC: begin
            arith   = {1'b0, bus.A} + {1'b0, op2};
            alu_res = arith[WIDTH-1:0];
            alu_c   = arith[WIDTH];
            alu_v   = (bus.A[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB, OP_CMP, OP_DEC: begin
            // bit WIDTH of the widened difference is the unsigned borrow
            arith   = {1'b0, bus.A} - {1'b0, op2};
            alu_res = arith[WIDTH-1:0];
            alu_c   = arith[WIDTH];
            alu_v   = (bus.A[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND: alu_res = bus.A & bus.B;
         OP_OR:  alu_res = bus.A | bus.B;
         OP_XOR: alu_res = bus.A ^ bus.B;
         OP_NOT: alu_res = ~bus.A;
         OP_SHL: begin
            // extra MSB catches the last bit shifted out (stays 0 for amt=0)
            sh      = {1'b0, bus.A} << amt;
            alu_res = sh[WIDTH-1:0];
            alu_c   = sh[WIDTH];
         end
         OP_SHR: begin
            sh      = {bus.A, 1'b0} >> amt;
            alu_res = sh[WIDTH:1];
            alu_c   = sh[0];
         end
         OP_ASR: begin
            sh      = $signed({bus.A, 1'b0}) >>> amt;
            alu_res = sh[WIDTH:1];
            alu_c   = sh[0];
         end
         OP_ROL: begin
            rot     = {bus.A, bus.A} << amt;
            alu_res = rot[2*WIDTH-1:WIDTH];
         end
         OP_ROR: begin
            rot     = {bus.A, bus.A} >> amt;
            alu_res = rot[WIDTH-1:0];
         end
         OP_PAS: alu_res = bus.B;
         default: alu_res = '0;
      endcase
   end

   // ---------------- multiplier step ----------------
   // acc_step is the accumulator after the current step; on the last step it
   // is the full product, so it can be written straight to the outputs.
   assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign prod_hi  = acc_step[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_reg    <= '0;
         mul_high_reg  <= '0;
         sreg_reg      <= '0;
         out_valid_reg <= 1'b0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
      end else begin
         out_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     mcand_reg  <= {{WIDTH{1'b0}}, bus.A};
                     mplier_reg <= bus.B;
                     acc_reg    <= '0;
                     cnt_reg    <= CNT_INIT;
                  end else begin
                     // CMP only updates flags
                     if (op != OP_CMP) begin
                        result_reg   <= alu_res;
                        mul_high_reg <= '0;
                     end
                     sreg_reg      <= {alu_v, alu_res[WIDTH-1], (alu_res == '0), alu_c};
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            BUSY: begin
               acc_reg    <= acc_step;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg - 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  result_reg    <= acc_step[WIDTH-1:0];
                  mul_high_reg  <= prod_hi;
                  sreg_reg      <= {(prod_hi != '0), acc_step[2*WIDTH-1],
                                    (acc_step == '0), (prod_hi != '0)};
                  out_valid_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result    = result_reg;
   assign bus.mul_high  = mul_high_reg;
   assign bus.SREG      = sreg_reg;
   assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Present one request at the falling edge, return 1 time unit after the
   // accepting rising edge with in_valid already dropped.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.function_select_lines = op;
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      $display("[TB] op=%0d A=%h B=%h -> result=%h mul_high=%h SREG=%b out_valid=%b",
               op, a, b, bus.result, bus.mul_high, bus.SREG, bus.out_valid);
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.function_select_lines = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      tests++; if (bus.result !== 8'h00) begin fails++; $display("FAIL reset_result: got %h want 00", bus.result); end
      tests++; if (bus.mul_high !== 8'h00) begin fails++; $display("FAIL reset_mul_high: got %h want 00", bus.mul_high); end
      tests++; if (bus.SREG !== 4'b0000) begin fails++; $display("FAIL reset_sreg: got %b want 0000", bus.SREG); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_idle: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
      $display("[TB] reset released");
   endtask

   task automatic test_add;
      issue(4'd0, 8'd127, 8'd125);
      tests++; if (bus.result !== 8'hFC) begin fails++; $display("FAIL add_result: got %h want fc", bus.result); end
      tests++; if (bus.SREG !== 4'b1100) begin fails++; $display("FAIL add_sreg: got %b want 1100", bus.SREG); end
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid: got %b want 1", bus.out_valid); end
      @(posedge clk);
      #1;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL add_pulse_width: got %b want 0", bus.out_valid); end
      tests++; if (bus.result !== 8'hFC) begin fails++; $display("FAIL add_hold: got %h want fc", bus.result); end
   endtask

   task automatic test_sub_cmp;
      issue(4'd1, 8'd5, 8'd5);
      tests++; if (bus.result !== 8'h00) begin fails++; $display("FAIL sub_result: got %h want 00", bus.result); end
      tests++; if (bus.SREG !== 4'b0010) begin fails++; $display("FAIL sub_sreg: got %b want 0010", bus.SREG); end
      issue(4'd11, 8'd3, 8'd6);
      tests++; if (bus.result !== 8'h00) begin fails++; $display("FAIL cmp_result_held: got %h want 00", bus.result); end
      tests++; if (bus.SREG !== 4'b0101) begin fails++; $display("FAIL cmp_sreg: got %b want 0101", bus.SREG); end
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL cmp_out_valid: got %b want 1", bus.out_valid); end
   endtask

   task automatic test_logic;
      logic [3:0] ops  [5] = '{4'd2,  4'd3,  4'd5,  4'd14, 4'd13};
      logic [7:0] as   [5] = '{8'hF0, 8'h0F, 8'h00, 8'h55, 8'h80};
      logic [7:0] bs   [5] = '{8'h3C, 8'hF0, 8'h12, 8'h00, 8'h77};
      logic [7:0] exp_r[5] = '{8'h30, 8'hFF, 8'hFF, 8'h00, 8'h7F};
      logic [3:0] exp_s[5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b1000};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i]);
         tests++; if (bus.result !== exp_r[i] || bus.SREG !== exp_s[i]) begin fails++; $display("FAIL logic_%0d: got result=%h SREG=%b want %h/%b", i, bus.result, bus.SREG, exp_r[i], exp_s[i]); end
      end
   endtask

   task automatic test_mul;
      int busy;
      int early;
      busy  = 0;
      early = 0;
      issue(4'd15, 8'd200, 8'd200);
      // keep a different request pending while busy; it must not be taken
      bus.in_valid = 1'b1;
      bus.function_select_lines = 4'd0;
      bus.A = 8'd1;
      bus.B = 8'd1;
      while (bus.in_ready !== 1'b1 && busy < 20) begin
         if (bus.out_valid === 1'b1) early++;
         busy++;
         @(posedge clk);
         #1;
      end
      tests++; if (busy != 8) begin fails++; $display("FAIL mul_busy_cycles: got %0d want 8", busy); end
      tests++; if (early != 0) begin fails++; $display("FAIL mul_early_valid: got %0d pulses want 0", early); end
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mul_out_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.result !== 8'h40 || bus.mul_high !== 8'h9C) begin fails++; $display("FAIL mul_product: got %h_%h want 9c_40", bus.mul_high, bus.result); end
      tests++; if (bus.SREG !== 4'b1101) begin fails++; $display("FAIL mul_sreg: got %b want 1101", bus.SREG); end
      $display("[TB] MUL done after %0d busy cycles: mul_high=%h result=%h SREG=%b", busy, bus.mul_high, bus.result, bus.SREG);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (bus.out_valid !== 1'b0 || bus.result !== 8'h40) begin fails++; $display("FAIL mul_no_extra: got out_valid=%b result=%h want 0/40", bus.out_valid, bus.result); end
   endtask

   task automatic test_shifts;
      logic [3:0] ops  [5] = '{4'd6,  4'd7,  4'd8,  4'd9,  4'd10};
      logic [7:0] as   [5] = '{8'h01, 8'h81, 8'h80, 8'h81, 8'h01};
      logic [7:0] bs   [5] = '{8'd7,  8'd1,  8'd2,  8'd1,  8'd1};
      logic [7:0] exp_r[5] = '{8'h80, 8'h40, 8'hE0, 8'h03, 8'h80};
      logic [3:0] exp_s[5] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0100};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i]);
         tests++; if (bus.result !== exp_r[i] || bus.SREG !== exp_s[i]) begin fails++; $display("FAIL shift_%0d: got result=%h SREG=%b want %h/%b", i, bus.result, bus.SREG, exp_r[i], exp_s[i]); end
         tests++; if (bus.mul_high !== 8'h00) begin fails++; $display("FAIL shift_%0d_mul_high: got %h want 00", i, bus.mul_high); end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] ops  [3] = '{4'd0,  4'd4,  4'd12};
      logic [7:0] as   [3] = '{8'd1,  8'h0F, 8'hFF};
      logic [7:0] bs   [3] = '{8'd2,  8'hFF, 8'h00};
      logic [7:0] exp_r[3] = '{8'h03, 8'hF0, 8'h00};
      logic [3:0] exp_s[3] = '{4'b0000, 4'b0100, 4'b0011};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.function_select_lines = ops[i];
         bus.A = as[i];
         bus.B = bs[i];
         @(posedge clk);
         #1;
         $display("[TB] b2b op=%0d A=%h B=%h -> result=%h SREG=%b out_valid=%b", ops[i], as[i], bs[i], bus.result, bus.SREG, bus.out_valid);
         tests++; if (bus.out_valid !== 1'b1 || bus.result !== exp_r[i] || bus.SREG !== exp_s[i]) begin fails++; $display("FAIL b2b_%0d: got ov=%b result=%h SREG=%b want 1/%h/%b", i, bus.out_valid, bus.result, bus.SREG, exp_r[i], exp_s[i]); end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_mul;
      int seen;
      seen = 0;
      issue(4'd13, 8'h00, 8'h00);
      tests++; if (bus.result !== 8'hFF || bus.SREG !== 4'b0101) begin fails++; $display("FAIL dec_wrap: got result=%h SREG=%b want ff/0101", bus.result, bus.SREG); end
      issue(4'd15, 8'd200, 8'd200);
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_mul_busy: got in_ready=%b want 0", bus.in_ready); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      $display("[TB] reset mid-MUL -> result=%h mul_high=%h SREG=%b in_ready=%b", bus.result, bus.mul_high, bus.SREG, bus.in_ready);
      tests++; if (bus.result !== 8'h00 || bus.mul_high !== 8'h00 || bus.SREG !== 4'b0000) begin fails++; $display("FAIL abort_outputs: got %h/%h/%b want 00/00/0000", bus.result, bus.mul_high, bus.SREG); end
      tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_handshake: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
      issue(4'd0, 8'd10, 8'd20);
      tests++; if (bus.out_valid !== 1'b1 || bus.result !== 8'h1E || bus.SREG !== 4'b0000) begin fails++; $display("FAIL post_abort_add: got ov=%b result=%h SREG=%b want 1/1e/0000", bus.out_valid, bus.result, bus.SREG); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_sub_cmp();
      test_logic();
      test_mul();
      test_shifts();
      test_back_to_back();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU.
- Takes WIDTH-bit operands and a 4-bit function code through a valid/ready handshake.
- Single-cycle ops are registered with 1-cycle latency. Multiply is an iterative shift-add (one step per clock), replacing the array multiplier to save area.
- Drives the result, the multiply high word and a 4-bit status register to the datapath/register file.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; combinational, high iff FSM in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; B[SHW-1:0] is the shift/rotate amount.
- function_select_lines  input  4  opcode.
- result  output  WIDTH  registered result (low word for MUL).
- mul_high  output  WIDTH  registered MUL high word; 0 after any non-MUL op.
- SREG  output  4  registered flags: [0]=C, [1]=Z, [2]=N, [3]=V.
- out_valid  output  1  one-cycle pulse: result/mul_high/SREG just updated.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, on port reset.
- Reset values: result=0, mul_high=0, SREG=0, out_valid=0, FSM=IDLE, step counter=0. in_ready=1 while reset is asserted.
- Accept: an op is accepted on a rising edge when in_valid && in_ready. Inputs are sampled only at accept.
- Opcodes:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL logical
  - 7 SHR logical
  - 8 ASR
  - 9 ROL
  - 10 ROR
  - 11 CMP
  - 12 INC A
  - 13 DEC A
  - 14 PASS B
  - 15 MUL unsigned
- Single-cycle ops (all except 15):
  - result, SREG and mul_high=0 are written on the accept edge. out_valid=1 for the following cycle.
  - FSM stays IDLE, so back-to-back accepts give one out_valid per op, every cycle.
- CMP: computes A-B flags only. result and mul_high are held; SREG is updated and out_valid pulses.
- Flags:
  - Z: result==0. N: result[WIDTH-1].
  - ADD/INC: C=carry out; V=signed overflow.
  - SUB/CMP/DEC: C=borrow (1 iff minuend < subtrahend, unsigned); V=signed overflow.
  - Shifts: C=last bit shifted out (0 when amount=0); V=0.
  - Logic, NOT, PASS, rotates: C=0, V=0.
- MUL FSM, IDLE -> MUL on accept:
  - Latch multiplicand and multiplier; clear accumulator; counter=WIDTH.
  - In MUL: in_ready=0. Each edge performs one shift-add step and decrements the counter.
  - On the WIDTH-th edge after accept: write {mul_high,result}=A*B (2*WIDTH bits), return to IDLE, out_valid=1 for the next cycle.
  - in_ready is high in the same cycle as out_valid.
  - MUL flags: Z=(full product==0); N=product[2*WIDTH-1]; C=V=(mul_high!=0).
- in_valid while busy: ignored, not queued. The requester must hold the request until in_ready.
- Output hold: outputs hold their last values until the next completion. out_valid is never high for more than 1 consecutive cycle per op.
- Reset mid-MUL: aborts immediately; no out_valid; outputs go to reset values.
- Arithmetic wraps modulo 2^WIDTH. Shift amounts >= WIDTH are not possible (SHW bits).

Test Plan:
- Flags, ADD: WIDTH=8, ADD A=127 B=125 -> next cycle result=0xFC, SREG C=0 Z=0 N=1 V=1, out_valid one cycle.
- Flags, SUB/CMP: SUB A=5 B=5 -> result=0, Z=1, C=0. Then CMP A=3 B=6 -> result still 0, C=1, N=1, Z=0, out_valid pulses.
- MUL latency: MUL A=200 B=200 -> in_ready low exactly 8 cycles; out_valid 8 edges after accept; result=0x40, mul_high=0x9C, C=V=1, Z=0. in_valid held high during busy accepts nothing extra.
- Shifts: SHL A=0x01 B=7 -> 0x80, C=0. SHR A=0x81 B=1 -> 0x40, C=1. ASR A=0x80 B=2 -> 0xE0. ROL A=0x81 B=1 -> 0x03. mul_high=0 after each.
- Back-to-back throughput: ADD 1+2, XOR 0x0F^0xFF, INC 0xFF on 3 consecutive cycles -> 3 consecutive out_valid with results 3, 0xF0, 0x00 (INC: C=1, Z=1).
- Reset mid-MUL: assert reset 3 cycles into MUL -> immediate zero outputs, no out_valid, in_ready=1. A subsequent ADD completes normally.
